// File: rtl/clk_gate_ctrl_if.sv
// clk_gate_ctrl_if
//   Bundles the requester-side and clock-gating-side signals of the
//   clock-enable scheduler.
//   Handshake: a requester holds REQ[i] high until it sees GNT[i]; it
//   then owns the gated resource until it pulses DONE for one cycle.
//   GNT/GNT_VLD/CLK_EN/STATE are registered and change only on CLK rising
//   edges (or immediately on RST).
//   Signals:
//     REQ      per-requester request level        (master -> slave)
//     DONE     one-cycle "grantee finished" pulse (master -> slave)
//     FORCE_ON keep gated clock running           (master -> slave)
//     GNT      one-hot grant                      (slave -> master)
//     GNT_VLD  OR of GNT                          (slave -> master)
//     CLK_EN   enable to clock-gating cell        (slave -> master)
//     STATE    scheduler FSM state, debug         (slave -> master)
interface clk_gate_ctrl_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] REQ;
  logic               DONE;
  logic               FORCE_ON;
  logic [NUM_REQ-1:0] GNT;
  logic               GNT_VLD;
  logic               CLK_EN;
  logic [1:0]         STATE;

  modport master (
    output REQ, DONE, FORCE_ON,
    input  GNT, GNT_VLD, CLK_EN, STATE
  );

  modport slave (
    input  REQ, DONE, FORCE_ON,
    output GNT, GNT_VLD, CLK_EN, STATE
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Clock-enable scheduler for a gated clock domain. Wakes the domain on
//   demand, waits WAKE_CYC cycles before the first grant, serialises
//   transactions with a round-robin arbiter, and turns the clock off after
//   IDLE_CYC idle cycles. Lives in the always-on domain.
//   Ports:
//     CLK  always-on clock
//     RST  asynchronous active-high reset
//     bus  clk_gate_ctrl_if slave modport (REQ/DONE/FORCE_ON in,
//          GNT/GNT_VLD/CLK_EN/STATE out, all outputs registered)
module clk_gate_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  clk_gate_ctrl_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [PTR_W:0]   NREQ_X    = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_WAKE   = 2'b01,
    S_ACTIVE = 2'b10,
    S_IDLE   = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_vld_q, clk_en_q;

  // Round-robin arbiter: first set REQ bit scanning upward from rr_ptr.
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic [NUM_REQ-1:0] win_onehot;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Extra bit holds rr_ptr + i before the wrap at NUM_REQ.
      cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
      if (cand >= NREQ_X) cand = cand - NREQ_X;
      if (!win_found && bus.REQ[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_d     = gnt_q;
    case (state_q)
      S_OFF: begin
        gnt_d = '0;
        if (|bus.REQ || bus.FORCE_ON) begin
          state_d = S_WAKE;
          cnt_d   = '0;
        end
      end
      S_WAKE: begin
        cnt_d = cnt_inc;
        if (cnt_q == WAKE_LAST) begin
          if (win_found) begin
            state_d   = S_ACTIVE;
            gnt_d     = win_onehot;
            gnt_idx_d = win_idx;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      S_ACTIVE: begin
        // Grant is frozen until DONE; REQ and FORCE_ON are not looked at.
        if (bus.DONE) begin
          rr_ptr_d = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
          gnt_d    = '0;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end
      S_IDLE: begin
        // A request beats the timeout when both land in the same cycle.
        if (win_found) begin
          state_d   = S_ACTIVE;
          gnt_d     = win_onehot;
          gnt_idx_d = win_idx;
        end else if (bus.FORCE_ON) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_OFF;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // CLK_EN and GNT_VLD are flopped from the next-state values so that both
  // are glitch-free and GNT_VLD can never be high while CLK_EN is low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= |gnt_d;
      clk_en_q  <= (state_d != S_OFF);
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.GNT_VLD = gnt_vld_q;
  assign bus.CLK_EN  = clk_en_q;
  assign bus.STATE   = state_q;

endmodule
